// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer between 2**IDW byte clients.
// It grants one client at a time, launches the byte, and holds the grant until the frame completes or times out.
module uart_tx_arbiter #(
   parameter int IDW         = 2,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [(2**IDW)-1:0]       req,
   input  logic [8*(2**IDW)-1:0]     din_flat,
   output logic [(2**IDW)-1:0]       ack,
   output logic [(2**IDW)-1:0]       done,
   output logic                      timeout_err,
   output logic                      busy,
   output logic [IDW-1:0]            grant_id,
   output logic                      tx_start,
   output logic [7:0]                tx_din,
   input  logic                      tx_done_tick
);

   localparam int          NREQ    = 2**IDW;
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    rr_q, rr_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              found;
   logic [IDW-1:0]    sel;

   logic [NREQ-1:0]   ack_d, done_d;
   logic              timeout_err_d, busy_d, tx_start_d;
   logic [IDW-1:0]    grant_id_d;
   logic [7:0]        tx_din_d;

   // Search rr, rr+1, ... with natural IDW-bit wrap; the first set bit wins.
   always_comb begin
      logic [IDW-1:0] idx;
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = rr_q + IDW'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (found) state_d = LAUNCH;
         LAUNCH:  state_d = WAIT;
         WAIT:    if (tx_done_tick || (cnt_q == TO_LAST)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of every registered output; done takes priority over timeout.
   always_comb begin
      ack_d         = '0;
      done_d        = '0;
      timeout_err_d = 1'b0;
      tx_start_d    = 1'b0;
      busy_d        = (state_d != IDLE);
      grant_id_d    = grant_id;
      tx_din_d      = tx_din;
      rr_d          = rr_q;
      cnt_d         = cnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_id_d = sel;
               tx_din_d   = din_flat[{sel, 3'b000} +: 8];
               rr_d       = sel + 1'b1;
               tx_start_d = 1'b1;
               ack_d[sel] = 1'b1;
            end
         end
         LAUNCH: cnt_d = '0;
         WAIT: begin
            if (tx_done_tick)          done_d[grant_id] = 1'b1;
            else if (cnt_q == TO_LAST) timeout_err_d    = 1'b1;
            else                       cnt_d            = cnt_q + 32'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q        <= '0;
         cnt_q       <= '0;
         ack         <= '0;
         done        <= '0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         grant_id    <= '0;
         tx_start    <= 1'b0;
         tx_din      <= '0;
      end else begin
         rr_q        <= rr_d;
         cnt_q       <= cnt_d;
         ack         <= ack_d;
         done        <= done_d;
         timeout_err <= timeout_err_d;
         busy        <= busy_d;
         grant_id    <= grant_id_d;
         tx_start    <= tx_start_d;
         tx_din      <= tx_din_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected launches and completions are queued by the
// stimulus, and a negedge monitor pops and compares them whenever the DUT reports an event.
module tb_uart_tx_arbiter;

   localparam int IDW  = 2;
   localparam int NREQ = 4;
   localparam int TO   = 50;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [8*NREQ-1:0] din_flat = '0;
   logic              tx_done_tick = 1'b0;
   logic [NREQ-1:0]   ack, done;
   logic              timeout_err, busy, tx_start;
   logic [IDW-1:0]    grant_id;
   logic [7:0]        tx_din;

   uart_tx_arbiter #(.IDW(IDW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .din_flat(din_flat),
      .ack(ack), .done(done), .timeout_err(timeout_err), .busy(busy),
      .grant_id(grant_id), .tx_start(tx_start), .tx_din(tx_din),
      .tx_done_tick(tx_done_tick)
   );

   always #5 clk = ~clk;

   typedef struct {logic [1:0] id; logic [7:0] data;} launch_t;
   typedef struct {bit is_to; logic [1:0] id; int rel;} end_t;

   launch_t launch_q[$];
   end_t    end_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_launch = 0;
   int done_delay = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor: compares every launch and every completion/timeout against the scoreboard.
   always @(negedge clk) begin : monitor
      launch_t le;
      end_t    ee;
      if (tx_start) begin
         last_launch = cyc;
         if (launch_q.size() == 0) flag("unexpected_launch");
         else begin
            le = launch_q.pop_front();
            check("grant_id", 32'(grant_id), 32'(le.id));
            check("tx_din", 32'(tx_din), 32'(le.data));
            check("ack_onehot", 32'(ack), 32'(1) << le.id);
            check("busy_at_launch", 32'(busy), 32'd1);
         end
      end else if (ack != '0) begin
         check("ack_without_start", 32'(ack), 32'd0);
      end
      if (done != '0 || timeout_err) begin
         if (end_q.size() == 0) flag("unexpected_done_or_timeout");
         else begin
            ee = end_q.pop_front();
            check("end_is_timeout", 32'(timeout_err), 32'(ee.is_to));
            if (ee.is_to) check("done_on_timeout", 32'(done), 32'd0);
            else          check("done_onehot", 32'(done), 32'(1) << ee.id);
            check("end_latency", 32'(cyc - last_launch), 32'(ee.rel));
            check("busy_at_end", 32'(busy), 32'd0);
         end
      end
   end

   // Stand-in for uart_tx: pulses tx_done_tick done_delay cycles after each launch (0 = never).
   always begin
      @(negedge clk);
      if (tx_start && done_delay != 0) begin
         repeat (done_delay) @(negedge clk);
         tx_done_tick = 1'b1;
         @(negedge clk);
         tx_done_tick = 1'b0;
      end
   end

   task automatic expect_launch(input logic [1:0] id, input logic [7:0] data);
      launch_q.push_back('{id: id, data: data});
   endtask

   task automatic expect_end(input bit is_to, input logic [1:0] id, input int rel);
      end_q.push_back('{is_to: is_to, id: id, rel: rel});
   endtask

   // Raises mask while idle, expects ack on the next cycle, then drops every request.
   task automatic issue(input logic [3:0] mask, input logic [1:0] id, input logic [7:0] data,
                        input int rel, input bit is_to);
      int n;
      expect_launch(id, data);
      if (rel > 0) expect_end(is_to, id, rel);
      @(negedge clk);
      req = mask;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ack == '0 && n < 20);
      check("ack_latency", 32'(n), 32'd1);
      req = '0;
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((launch_q.size() != 0 || end_q.size() != 0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (n >= bound) begin
         flag("drain_timeout");
         launch_q.delete();
         end_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"}, 32'(ack), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
      check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
      check({tag, "_tx_din"}, 32'(tx_din), 32'd0);
   endtask

   initial begin
      int nack;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      // Single requester 2 with byte 0xA5; tick 12 cycles after launch.
      din_flat   = 32'h00A5_0000;
      done_delay = 12;
      issue(4'b0100, 2'd2, 8'hA5, 13, 1'b0);
      drain(200);

      // Rotation from rr=0 with all four requests held.
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      din_flat   = 32'h1312_1110;
      done_delay = 6;
      expect_launch(2'd0, 8'h10); expect_end(1'b0, 2'd0, 7);
      expect_launch(2'd1, 8'h11); expect_end(1'b0, 2'd1, 7);
      expect_launch(2'd2, 8'h12); expect_end(1'b0, 2'd2, 7);
      expect_launch(2'd3, 8'h13); expect_end(1'b0, 2'd3, 7);
      expect_launch(2'd0, 8'h10); expect_end(1'b0, 2'd0, 7);
      req  = 4'b1111;
      nack = 0;
      for (int i = 0; i < 500 && nack < 5; i++) begin
         @(negedge clk);
         if (ack != '0) nack++;
      end
      req = '0;
      check("rotation_acks", 32'(nack), 32'd5);
      drain(200);

      // Fairness: rr=1 here; grant 1 then 0011 -> 0; grant 1 then 1001 -> 3.
      done_delay = 4;
      issue(4'b0010, 2'd1, 8'h11, 5, 1'b0); drain(100);
      issue(4'b0011, 2'd0, 8'h10, 5, 1'b0); drain(100);
      issue(4'b0010, 2'd1, 8'h11, 5, 1'b0); drain(100);
      issue(4'b1001, 2'd3, 8'h13, 5, 1'b0); drain(100);

      // Timeout: no tick, timeout_err 50 cycles after WAIT entry (51 after launch).
      done_delay = 0;
      issue(4'b0001, 2'd0, 8'h10, 51, 1'b1); drain(200);
      done_delay = 5;
      issue(4'b0100, 2'd2, 8'h12, 6, 1'b0); drain(100);

      // Collision: tick on the last permitted WAIT cycle -> done wins.
      done_delay = 50;
      issue(4'b1000, 2'd3, 8'h13, 51, 1'b0); drain(200);

      // Asynchronous reset in WAIT; the stale tick later lands in IDLE and must be ignored.
      done_delay = 30;
      issue(4'b0001, 2'd0, 8'h10, 0, 1'b0);
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_all_zero("async_reset");
      @(negedge clk) reset = 1'b0;
      repeat (40) @(negedge clk);
      done_delay = 8;
      issue(4'b0010, 2'd1, 8'h11, 9, 1'b0); drain(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
